mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one shared memory port.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration instead of data priority with a fetch starvation limit.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [3:0]        dm_sel_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_sel_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   grant_dm;   // owner of the transaction in flight
  logic   txn_we;     // in-flight transaction is a write; no read data returned
  logic   dm_wins;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;

  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    dm_wins = dm_req_i & (~if_req_i | ~last_dm);
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    dm_wins = dm_req_i & (~if_req_i | (starve_cnt < CNT_MAX));
  end
`endif

  assign stall_req_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_dm    <= 1'b0;
      txn_we      <= 1'b0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_ce_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_sel_o   <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm     <= 1'b0;
`else
      starve_cnt  <= '0;
`endif
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req_i || dm_req_i) begin
            state    <= ISSUE;
            mem_ce_o <= 1'b1;
            grant_dm <= dm_wins;
            if (dm_wins) begin
              txn_we      <= dm_we_i;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              mem_sel_o   <= dm_sel_i;
            end else begin
              txn_we      <= 1'b0;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              mem_sel_o   <= 4'b1111;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_dm <= dm_wins;
`else
            if (!dm_wins)
              starve_cnt <= '0;
            else if (if_req_i && starve_cnt < CNT_MAX)
              starve_cnt <= starve_cnt + 1'b1;
`endif
          end
        end
        ISSUE: begin
          state    <= RESP;
          mem_ce_o <= 1'b0;
          mem_we_o <= 1'b0;
        end
        RESP: begin
          // Memory data is valid in this cycle; the owner is acknowledged even if it dropped its request.
          state <= IDLE;
          if (grant_dm) begin
            dm_ack_o   <= 1'b1;
            dm_rdata_o <= txn_we ? '0 : mem_rdata_i;
          end else begin
            if_ack_o   <= 1'b1;
            if_rdata_o <= mem_rdata_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: reset, fetch, write, dropped request, arbitration and reset abort.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_sel = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata = '0;
  logic        stall;

  int n_run  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_sel_i(dm_sel), .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_sel_o(mem_sel), .mem_rdata_i(mem_rdata), .stall_req_o(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Synchronous memory: read data appears the cycle after mem_ce, garbage otherwise.
  always @(posedge clk) begin
    if (mem_ce && !mem_we) mem_rdata <= mem_model(mem_addr);
    else                   mem_rdata <= 32'hBAD0_0BAD;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    step();
    step();
    n_run++;
    if ({if_ack, dm_ack, mem_ce, mem_we, mem_sel, stall} !== 10'b0 ||
        if_rdata !== 32'h0 || dm_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b/%b ce=%b we=%b sel=%b stall=%b rdata=%h/%h addr=%h, required all 0",
               if_ack, dm_ack, mem_ce, mem_we, mem_sel, stall, if_rdata, dm_rdata, mem_addr);
    end
    rst = 1'b0;
    step();
    n_run++;
    if (mem_ce !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: ce=%b acks=%b/%b, required 0", mem_ce, if_ack, dm_ack);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_run++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_req: stall=%b, required 1", stall); end
    step();  // edge N samples the request
    n_run++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_sel !== 4'b1111 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_issue: ce=%b we=%b sel=%b addr=%h, required 1 0 1111 00000100", mem_ce, mem_we, mem_sel, mem_addr);
    end
    step();
    n_run++;
    if (mem_ce !== 1'b0 || if_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp_phase: ce=%b ack=%b, required 0 0", mem_ce, if_ack);
    end
    step();
    n_run++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h13 || dm_ack !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ack: ack=%b rdata=%h dm_ack=%b stall=%b, required 1 00000013 0 0", if_ack, if_rdata, dm_ack, stall);
    end
    if_req = 1'b0;
    step();
    n_run++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h13 || mem_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_hold: ack=%b rdata=%h ce=%b, required 0 00000013 0", if_ack, if_rdata, mem_ce);
    end
  endtask

  task automatic test_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_sel = 4'b0011;
    step();
    n_run++;
    if (mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_sel !== 4'b0011 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_issue: ce=%b we=%b sel=%b addr=%h wdata=%h, required 1 1 0011 00000200 deadbeef",
               mem_ce, mem_we, mem_sel, mem_addr, mem_wdata);
    end
    step();
    n_run++;
    if (mem_ce !== 1'b0 || mem_we !== 1'b0 || dm_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp_phase: ce=%b we=%b ack=%b, required 0 0 0", mem_ce, mem_we, dm_ack);
    end
    step();
    n_run++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h0 || if_ack !== 1'b0 || if_rdata !== 32'h13) begin
      n_fail++;
      $display("FAIL write_ack: dm_ack=%b dm_rdata=%h if_ack=%b if_rdata=%h, required 1 00000000 0 00000013",
               dm_ack, dm_rdata, if_ack, if_rdata);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
  endtask

  task automatic test_dropped_request();
    if_req = 1'b1; if_addr = 32'h104;
    step();
    if_req = 1'b0;  // dropped while the transaction is in flight
    step();
    step();
    n_run++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h0104_C0DE) begin
      n_fail++;
      $display("FAIL dropped_req_ack: ack=%b rdata=%h, required 1 0104c0de", if_ack, if_rdata);
    end
    step();
  endtask

  task automatic test_arbitration();
    logic exp_dm [10];
    int   n_grant = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_dm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    do_reset();
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800; dm_sel = 4'b1111;
    for (int c = 0; c < 31; c++) begin
      step();
      n_run++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL arb_stall cycle %0d: stall=%b, required 1", c, stall); end
      if (mem_ce === 1'b1 && n_grant < 10) begin
        n_run++;
        if ((mem_addr === 32'h800) !== exp_dm[n_grant]) begin
          n_fail++;
          $display("FAIL arb_grant #%0d: addr=%h, required %s", n_grant, mem_addr, exp_dm[n_grant] ? "dm" : "if");
        end
        n_grant++;
      end
      if (if_ack === 1'b1) begin
        n_run++;
        if (if_rdata !== 32'h0400_C0DE || dm_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL arb_if_ack: rdata=%h dm_ack=%b, required 0400c0de 0", if_rdata, dm_ack);
        end
      end
      if (dm_ack === 1'b1) begin
        n_run++;
        if (dm_rdata !== 32'h0800_C0DE) begin
          n_fail++;
          $display("FAIL arb_dm_ack: rdata=%h, required 0800c0de", dm_rdata);
        end
      end
    end
    n_run++;
    if (n_grant != 10) begin n_fail++; $display("FAIL arb_grant_count: got %0d, required 10", n_grant); end
    if_req = 1'b0; dm_req = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_abort();
    bit seen_ack = 1'b0;
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_sel = 4'b1111;
    step();
    n_run++;
    if (mem_ce !== 1'b1) begin n_fail++; $display("FAIL abort_issue: ce=%b, required 1", mem_ce); end
    rst = 1'b1;
    step();
    n_run++;
    if (mem_ce !== 1'b0 || dm_ack !== 1'b0 || dm_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset: ce=%b ack=%b rdata=%h, required 0 0 00000000", mem_ce, dm_ack, dm_rdata);
    end
    rst = 1'b0;
    step();  // request re-sampled here
    n_run++;
    if (mem_ce !== 1'b1 || dm_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reissue: ce=%b ack=%b, required 1 0", mem_ce, dm_ack);
    end
    step();
    seen_ack = dm_ack;
    step();
    n_run++;
    if (seen_ack !== 1'b0 || dm_ack !== 1'b1 || dm_rdata !== 32'h0300_C0DE) begin
      n_fail++;
      $display("FAIL abort_reserve: early_ack=%b ack=%b rdata=%h, required 0 1 0300c0de", seen_ack, dm_ack, dm_rdata);
    end
    dm_req = 1'b0;
    step();
    n_run++;
    if (dm_ack !== 1'b0 || mem_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: ack=%b ce=%b, required 0 0", dm_ack, mem_ce);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_dropped_request();
    test_arbitration();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
